// File: rtl/cus19_alu_arbiter.sv
// Shares one ALU between pipeline (port 0) and crypto (port 1); optional round-robin via CUS19_ALU_ARB_RR_EN.
// Latency: accept at T, ALU enabled at T+1, response valid at T+2; min 3 cycles between accepts.
// Backpressure: requests wait for one-hot ready; response held stable until owner's resp_ready_in.
`timescale 1ns/1ps
module cus19_alu_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 2*DATA_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [1:0]                req_valid_in,
    output logic [1:0]                req_ready_out,
    input  logic [2*DATA_WIDTH-1:0]   req_op1_in,
    input  logic [2*DATA_WIDTH-1:0]   req_op2_in,
    input  logic [7:0]                req_funct_in,
    output logic [1:0]                resp_valid_out,
    input  logic [1:0]                resp_ready_in,
    output logic [RESULT_WIDTH-1:0]   resp_data_out,
    output logic                      resp_dz_out,
    output logic [DATA_WIDTH-1:0]     alu_op1_out,
    output logic [DATA_WIDTH-1:0]     alu_op2_out,
    output logic [3:0]                alu_funct_out,
    output logic                      alu_en_out,
    input  logic [RESULT_WIDTH-1:0]   alu_result_in,
    output logic                      busy_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] FUNCT_DIV = 4'd3;

    state_t          state;
    logic            owner;
    logic [1:0]      grant;
    logic            sel;
    logic [DATA_WIDTH-1:0] sel_op1;
    logic [DATA_WIDTH-1:0] sel_op2;
    logic [3:0]      sel_funct;

`ifdef CUS19_ALU_ARB_RR_EN
    logic            last_gnt;
`endif

    // Grant is gated by reset so ready reads 0 while reset is asserted.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE && rst_n_in) begin
            case (req_valid_in)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
`ifdef CUS19_ALU_ARB_RR_EN
                2'b11:   grant = last_gnt ? 2'b01 : 2'b10;
`else
                2'b11:   grant = 2'b01;
`endif
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready_out = grant;
    assign sel       = grant[1];
    assign sel_op1   = sel ? req_op1_in[DATA_WIDTH +: DATA_WIDTH] : req_op1_in[0 +: DATA_WIDTH];
    assign sel_op2   = sel ? req_op2_in[DATA_WIDTH +: DATA_WIDTH] : req_op2_in[0 +: DATA_WIDTH];
    assign sel_funct = sel ? req_funct_in[7:4] : req_funct_in[3:0];
    assign busy_out  = (state != IDLE);

    // The alu_* registers double as the latched request; they are zeroed once the result is captured.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            owner          <= 1'b0;
            alu_op1_out    <= '0;
            alu_op2_out    <= '0;
            alu_funct_out  <= '0;
            alu_en_out     <= 1'b0;
            resp_valid_out <= 2'b00;
            resp_data_out  <= '0;
            resp_dz_out    <= 1'b0;
`ifdef CUS19_ALU_ARB_RR_EN
            last_gnt       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        alu_op1_out   <= sel_op1;
                        alu_op2_out   <= sel_op2;
                        alu_funct_out <= sel_funct;
                        alu_en_out    <= 1'b1;
                        owner         <= sel;
`ifdef CUS19_ALU_ARB_RR_EN
                        last_gnt      <= sel;
`endif
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (alu_funct_out == FUNCT_DIV && alu_op2_out == '0) begin
                        resp_data_out <= '1;
                        resp_dz_out   <= 1'b1;
                    end else begin
                        resp_data_out <= alu_result_in;
                        resp_dz_out   <= 1'b0;
                    end
                    resp_valid_out <= owner ? 2'b10 : 2'b01;
                    alu_op1_out    <= '0;
                    alu_op2_out    <= '0;
                    alu_funct_out  <= '0;
                    alu_en_out     <= 1'b0;
                    state          <= RESP;
                end
                RESP: begin
                    if (resp_ready_in[owner]) begin
                        resp_valid_out <= 2'b00;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cus19_alu_arbiter.sv
// Directed bench for cus19_alu_arbiter: vector table plus conflict and mid-response reset sequences.
`timescale 1ns/1ps
module tb_cus19_alu_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [1:0]  req_valid_in;
    logic [1:0]  req_ready_out;
    logic [15:0] req_op1_in;
    logic [15:0] req_op2_in;
    logic [7:0]  req_funct_in;
    logic [1:0]  resp_valid_out;
    logic [1:0]  resp_ready_in;
    logic [15:0] resp_data_out;
    logic        resp_dz_out;
    logic [7:0]  alu_op1_out;
    logic [7:0]  alu_op2_out;
    logic [3:0]  alu_funct_out;
    logic        alu_en_out;
    logic [15:0] alu_result_in;
    logic        busy_out;

    int checks = 0;
    int failures = 0;

    cus19_alu_arbiter #(.DATA_WIDTH(8), .RESULT_WIDTH(16)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_op1_in(req_op1_in), .req_op2_in(req_op2_in), .req_funct_in(req_funct_in),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
        .resp_data_out(resp_data_out), .resp_dz_out(resp_dz_out),
        .alu_op1_out(alu_op1_out), .alu_op2_out(alu_op2_out),
        .alu_funct_out(alu_funct_out), .alu_en_out(alu_en_out),
        .alu_result_in(alu_result_in), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural ALU; divide by zero deliberately returns 0 so the arbiter's override is visible.
    always_comb begin
        alu_result_in = 16'h0000;
        case (alu_funct_out)
            4'd0: alu_result_in = {8'h00, alu_op1_out} + {8'h00, alu_op2_out};
            4'd1: alu_result_in = {8'h00, alu_op1_out} - {8'h00, alu_op2_out};
            4'd2: alu_result_in = {8'h00, alu_op1_out} * {8'h00, alu_op2_out};
            4'd3: alu_result_in = (alu_op2_out == 8'h00) ? 16'h0000 :
                                  {alu_op1_out % alu_op2_out, alu_op1_out / alu_op2_out};
            4'd4: alu_result_in = {8'h00, alu_op1_out} + 16'd1;
            4'd5: alu_result_in = {8'h00, alu_op1_out} - 16'd1;
            4'd6: alu_result_in = {8'h00, alu_op1_out & alu_op2_out};
            4'd7: alu_result_in = {8'h00, alu_op1_out | alu_op2_out};
            4'd8: alu_result_in = {8'h00, alu_op1_out ^ alu_op2_out};
            4'd9: alu_result_in = {8'h00, ~alu_op1_out};
            default: alu_result_in = 16'h0000;
        endcase
    end

    typedef struct {
        int          port;
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [3:0]  funct;
        int          hold;
        logic [15:0] exp_data;
        logic        exp_dz;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at negedge+1 of the accept cycle; walks ISSUE and RESP and returns at negedge+1 back in IDLE.
    task automatic finish_op(input int port, input int hold, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [3:0] ef, input logic [15:0] ed, input logic edz, input bit drop);
        logic [1:0] mask;
        mask = (port == 1) ? 2'b10 : 2'b01;
        @(negedge clk_in); #1;
        if (drop) req_valid_in[port] = 1'b0;
        chk("issue_alu_en", 32'(alu_en_out), 32'd1);
        chk("issue_alu_op1", 32'(alu_op1_out), 32'(e1));
        chk("issue_alu_op2", 32'(alu_op2_out), 32'(e2));
        chk("issue_alu_funct", 32'(alu_funct_out), 32'(ef));
        chk("issue_req_ready", 32'(req_ready_out), 32'd0);
        chk("issue_busy", 32'(busy_out), 32'd1);
        chk("issue_resp_valid", 32'(resp_valid_out), 32'd0);
        @(negedge clk_in); #1;
        chk("resp_alu_en", 32'(alu_en_out), 32'd0);
        chk("resp_alu_op1", 32'(alu_op1_out), 32'd0);
        chk("resp_valid", 32'(resp_valid_out), 32'(mask));
        chk("resp_data", 32'(resp_data_out), 32'(ed));
        chk("resp_dz", 32'(resp_dz_out), 32'(edz));
        if (hold > 0) begin
            resp_ready_in = ~mask;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk_in); #1;
                chk("hold_resp_valid", 32'(resp_valid_out), 32'(mask));
                chk("hold_resp_data", 32'(resp_data_out), 32'(ed));
                chk("hold_resp_dz", 32'(resp_dz_out), 32'(edz));
                chk("hold_req_ready", 32'(req_ready_out), 32'd0);
            end
        end
        resp_ready_in = mask;
        @(negedge clk_in); #1;
        resp_ready_in = 2'b00;
        chk("done_busy", 32'(busy_out), 32'd0);
        chk("done_resp_valid", 32'(resp_valid_out), 32'd0);
    endtask

    task automatic run_op(input vec_t v);
        logic [1:0] mask;
        mask = (v.port == 1) ? 2'b10 : 2'b01;
        req_op1_in[v.port*8 +: 8]   = v.op1;
        req_op2_in[v.port*8 +: 8]   = v.op2;
        req_funct_in[v.port*4 +: 4] = v.funct;
        req_valid_in[v.port]        = 1'b1;
        #1;
        chk("accept_req_ready", 32'(req_ready_out), 32'(mask));
        finish_op(v.port, v.hold, v.op1, v.op2, v.funct, v.exp_data, v.exp_dz, 1'b1);
    endtask

    initial begin
        int exp_order[8];
        int cnt[2];
        int p;
        logic [1:0] g;
        vec_t sub_v;

        vecs[0] = '{port: 0, op1: 8'h0F, op2: 8'h01, funct: 4'd0,  hold: 0, exp_data: 16'h0010, exp_dz: 1'b0};
        vecs[1] = '{port: 0, op1: 8'd7,  op2: 8'd0,  funct: 4'd3,  hold: 0, exp_data: 16'hFFFF, exp_dz: 1'b1};
        vecs[2] = '{port: 0, op1: 8'd7,  op2: 8'd2,  funct: 4'd3,  hold: 0, exp_data: 16'h0103, exp_dz: 1'b0};
        vecs[3] = '{port: 1, op1: 8'hF0, op2: 8'h3C, funct: 4'd6,  hold: 0, exp_data: 16'h0030, exp_dz: 1'b0};
        vecs[4] = '{port: 0, op1: 8'h5A, op2: 8'h00, funct: 4'd9,  hold: 0, exp_data: 16'h00A5, exp_dz: 1'b0};
        vecs[5] = '{port: 1, op1: 8'h11, op2: 8'h22, funct: 4'd12, hold: 0, exp_data: 16'h0000, exp_dz: 1'b0};
        vecs[6] = '{port: 0, op1: 8'hFF, op2: 8'h00, funct: 4'd4,  hold: 0, exp_data: 16'h0100, exp_dz: 1'b0};
        vecs[7] = '{port: 1, op1: 8'hFF, op2: 8'hFF, funct: 4'd2,  hold: 4, exp_data: 16'hFE01, exp_dz: 1'b0};

`ifdef CUS19_ALU_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif

        rst_n_in      = 1'b0;
        req_valid_in  = 2'b01;
        req_op1_in    = 16'h0000;
        req_op2_in    = 16'h0000;
        req_funct_in  = 8'h00;
        resp_ready_in = 2'b00;
        #2;
        chk("rst_req_ready", 32'(req_ready_out), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid_out), 32'd0);
        chk("rst_resp_data", 32'(resp_data_out), 32'd0);
        chk("rst_resp_dz", 32'(resp_dz_out), 32'd0);
        chk("rst_alu_en", 32'(alu_en_out), 32'd0);
        chk("rst_alu_op1", 32'(alu_op1_out), 32'd0);
        chk("rst_alu_funct", 32'(alu_funct_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        req_valid_in = 2'b00;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in); #1;
        chk("idle_no_req_ready", 32'(req_ready_out), 32'd0);
        chk("idle_busy", 32'(busy_out), 32'd0);

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Both ports request continuously; each drops valid after its fourth accept.
        req_op1_in   = {8'h0F, 8'h03};
        req_op2_in   = {8'hFF, 8'h04};
        req_funct_in = {4'd8, 4'd0};
        req_valid_in = 2'b11;
        cnt = '{0, 0};
        #1;
        for (int k = 0; k < 8; k++) begin
            g = req_ready_out;
            chk("conflict_grant", 32'(g), (exp_order[k] == 1) ? 32'd2 : 32'd1);
            if (g == 2'b01) p = 0;
            else if (g == 2'b10) p = 1;
            else break;
            cnt[p]++;
            if (p == 0) finish_op(0, 0, 8'h03, 8'h04, 4'd0, 16'h0007, 1'b0, cnt[0] == 4);
            else        finish_op(1, 0, 8'h0F, 8'hFF, 4'd8, 16'h00F0, 1'b0, cnt[1] == 4);
        end
        req_valid_in = 2'b00;
        @(negedge clk_in); #1;

        // Reset while a divide-by-zero response is waiting.
        req_op1_in[7:0]   = 8'd7;
        req_op2_in[7:0]   = 8'd0;
        req_funct_in[3:0] = 4'd3;
        req_valid_in      = 2'b01;
        @(negedge clk_in); #1;
        req_valid_in = 2'b00;
        @(negedge clk_in); #1;
        chk("prerst_resp_valid", 32'(resp_valid_out), 32'd1);
        chk("prerst_resp_dz", 32'(resp_dz_out), 32'd1);
        rst_n_in = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid_out), 32'd0);
        chk("midrst_resp_data", 32'(resp_data_out), 32'd0);
        chk("midrst_resp_dz", 32'(resp_dz_out), 32'd0);
        chk("midrst_busy", 32'(busy_out), 32'd0);
        chk("midrst_alu_en", 32'(alu_en_out), 32'd0);
        chk("midrst_req_ready", 32'(req_ready_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in); #1;
        sub_v = '{port: 1, op1: 8'd5, op2: 8'd3, funct: 4'd1, hold: 0, exp_data: 16'h0002, exp_dz: 1'b0};
        run_op(sub_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cus19_alu_arbiter.md
# cus19_alu_arbiter

Shares the single IE-stage ALU between two requesters: port 0 (core pipeline) and port 1 (crypto accelerator). The block accepts one operation at a time over a valid/ready handshake, drives the ALU operand and function bus for one issue cycle, and registers the 16-bit result. It then holds that result on the winning port's response channel until the requester accepts it. It sits between the pipeline/crypto issue logic and the ALU.

## Interface
- DATA_WIDTH, 8, operand width; must match the ALU's Data_Width.
- RESULT_WIDTH, 2*DATA_WIDTH, result width; must match the ALU's Result_Width.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  reset; asynchronous, active-low.
- req_valid_in  input  2  per-port request valid; bit i belongs to port i.
- req_ready_out  output  2  per-port request ready; one-hot or zero.
- req_op1_in  input  2*DATA_WIDTH  operand 1; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_op2_in  input  2*DATA_WIDTH  operand 2; same packing as req_op1_in.
- req_funct_in  input  8  function code; port i occupies [i*4 +: 4]. Encoding: ADD 0, SUB 1, MUL 2, DIV 3, INC 4, DEC 5, AND 6, OR 7, XOR 8, NOT 9.
- resp_valid_out  output  2  per-port response valid; one-hot or zero.
- resp_ready_in  input  2  per-port response ready.
- resp_data_out  output  RESULT_WIDTH  registered result; shared by both ports, qualified by resp_valid_out.
- resp_dz_out  output  1  divide-by-zero flag for the current response.
- alu_op1_out  output  DATA_WIDTH  ALU operand 1.
- alu_op2_out  output  DATA_WIDTH  ALU operand 2.
- alu_funct_out  output  4  ALU function select.
- alu_en_out  output  1  ALU enable.
- alu_result_in  input  RESULT_WIDTH  combinational ALU result.
- busy_out  output  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- **IDLE**
  - The grant is computed combinationally from req_valid_in and the arbitration policy.
  - req_ready_out equals the one-hot grant; it is 0 if no port is valid.
  - On handshake (req_valid_in[i] and req_ready_out[i]): latch op1, op2, funct and the owner index i, then go to ISSUE.
- **ISSUE** (always exactly one cycle)
  - alu_en_out=1; alu_* outputs are driven from the latched registers.
  - Capture alu_result_in into resp_data_out, then go to RESP.
  - Divide-by-zero: if funct==DIV and op2==0, force resp_data_out to all ones and set resp_dz_out=1. Otherwise resp_dz_out=0.
- **RESP**
  - resp_valid_out[owner]=1.
  - When resp_ready_in[owner]=1, go to IDLE.
  - resp_ready_in of the non-owner port is ignored.
- Outside ISSUE: alu_en_out=0 and the alu_* outputs are driven to 0.
- Unknown funct codes (10-15) pass through to the ALU unchanged; the ALU returns 0.
- req_ready_out is 0 in ISSUE and RESP.

## Timing
- Reset values: req_ready_out=0, resp_valid_out=0, resp_data_out=0, resp_dz_out=0, alu_op1_out=0, alu_op2_out=0, alu_funct_out=0, alu_en_out=0, busy_out=0, owner=0, round-robin last-grant pointer=1.
- With no requests pending at reset exit, req_ready_out stays 0 until a port raises valid; it is not held at 0 because of reset.
- Latency: request accepted in cycle T, alu_en_out high in T+1, resp_valid_out high in T+2.
- Minimum spacing between accepted requests: 3 cycles, when the response is accepted in the same cycle it is presented.
- resp_data_out and resp_dz_out hold stable for the whole time resp_valid_out is high.
- A request asserted while the block is busy must stay asserted with stable operands until it receives ready.
- Simultaneous valid on both ports in IDLE: resolved by the arbitration policy (see Configuration).
- Reset mid-operation (ISSUE or RESP): return immediately to IDLE; the in-flight result is discarded and resp_valid_out drops asynchronously.

## Configuration
- CUS19_ALU_ARB_RR_EN defined: round-robin arbitration.
  - On a conflict, grant the port not granted last.
  - The pointer updates on every accepted request and resets to 1, so port 0 wins the first conflict.
- CUS19_ALU_ARB_RR_EN undefined: fixed priority; port 0 always wins a conflict and the pointer logic is absent.
- Single-requester behaviour is identical in both builds.

## Test plan
- Port 0 ADD 8'h0F+8'h01, resp_ready_in held 1 -> alu_en_out high for exactly one cycle at T+1; resp_valid_out=2'b01 at T+2 with resp_data_out=16'h0010.
- Port 1 MUL 8'hFF*8'hFF with resp_ready_in[1] held 0 for 4 cycles -> resp_data_out=16'hFE01 stable throughout; req_ready_out=0 until the handshake, then the block returns to IDLE.
- Port 0 DIV 8'd7/8'd0 -> resp_data_out=16'hFFFF, resp_dz_out=1. Then DIV 8'd7/8'd2 -> 16'h0103 (remainder 1, quotient 3), resp_dz_out=0.
- Both ports valid continuously for 4 requests each. RR build -> grants alternate 0,1,0,1. Fixed build -> all four port-0 requests complete before the first port-1 request.
- Assert rst_n_in low during RESP -> all outputs return to their reset values immediately and busy_out=0; after release, a new port-1 SUB 8'd5-8'd3 returns 16'h0002.
